button_valid_array: RTL
=======================

# button_valid_array

Multi-channel successor to the single-button valid generator. Synchronises and debounces `CHANNELS` raw push-button inputs, emits a one-cycle `valid` pulse per confirmed press, and keeps a wrapping press counter per channel. Sits between board-level button pins and any consumer that needs clean, single-cycle press events.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to accept a level change (≥1).
- `CNT_W`, 8: width of each press counter.
- `LONG_CYCLES`, 16: held cycles after press acceptance that signal a long press (≥1; used only with the macro).

- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `button`  in  CHANNELS  raw asynchronous button levels, 1 = pressed.
- `clear`  in  1  synchronous clear of all press counters.
- `pressed`  out  CHANNELS  debounced stable level per channel.
- `valid`  out  CHANNELS  one-cycle pulse on each accepted 0→1 transition.
- `press_count`  out  CHANNELS*CNT_W  per-channel press count; channel i at bits [i*CNT_W +: CNT_W].
- `long_press`  out  CHANNELS  one-cycle long-press pulse (see Configuration).

## Operation
- Per channel: 2-flop synchroniser, then a 4-state debounce FSM: `LOW` → `CHK_HI` → `HIGH` → `CHK_LO` → `LOW`.
- `LOW`: sync=1 → `CHK_HI`, debounce count = 1. `CHK_HI`: sync=1 → count+1; reaching `DEBOUNCE_CYCLES` → `HIGH`, `pressed`=1, `valid`=1 for that cycle; sync=0 → back to `LOW`, count = 0.
- `HIGH`/`CHK_LO`: mirror image; accepting a release sets `pressed`=0 and does not pulse `valid`.
- `DEBOUNCE_CYCLES`=1: the first mismatching sample is accepted directly (no dwell in CHK state).
- `press_count` increments by 1 on every `valid` pulse; wraps 2^CNT_W−1 → 0, no saturation, no flag.
- `clear` zeroes all counters; `clear` and `valid` in the same cycle: `clear` wins, count = 0.
- Channels are fully independent; simultaneous presses on several channels all pulse and count in the same cycle.
- Reset values: `pressed`=0, `valid`=0, `press_count`=0, `long_press`=0, FSM=`LOW`, synchronisers=0, all internal counters 0.
- Reset mid-press aborts all state; a button still held after reset release is debounced again as a new press.

## Timing
- `button` high before edge k (and held): `valid` and `pressed` high after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycle latency. With DEBOUNCE_CYCLES=4, this is 6 cycles.
- `valid` is high for exactly one cycle per press, however long the button is held.
- `press_count` reflects the press one cycle after `valid` (registered off `valid`).
- Glitches shorter than DEBOUNCE_CYCLES synchronised samples produce no output change.
- Release latency equals press latency; there is no `valid` on release.

## Configuration
- `BUTTON_LONG_PRESS_EN` defined: per-channel hold counter runs while in `HIGH`/`CHK_LO`. It pulses `long_press` for one cycle when the count reaches `LONG_CYCLES` after `valid`, at most once per press. The counter clears on release acceptance or reset.
- Not defined: hold counters are not synthesised and `long_press` is tied to 0; the port list is unchanged.

## Structure
- Package `button_valid_pkg`: debounce FSM state enum `deb_state_t` (`LOW`, `CHK_HI`, `HIGH`, `CHK_LO`) and default parameter constants.
- Sub-module `button_debounce_ch`: one channel (synchroniser, FSM, `valid`, optional long-press logic), instantiated `CHANNELS` times by generate. Counters and `clear` live in the top.

## Test plan
- Reset held 5 cycles, then `button`=0: all outputs remain 0, and `press_count` remains 0 on every channel.
- Channel 0 high for 10 cycles (D=4): `valid[0]` pulses once, 6 cycles after the rise. `press_count[0]`=1 and `pressed[0]` falls 6 cycles after release.
- Channel 1 high for 2 cycles, then low: no `valid`, `pressed[1]` stays 0, and the count is unchanged.
- 256 clean presses on channel 2 with CNT_W=8: count wraps to 0, and other channels stay 0.
- `clear` asserted in the same cycle as `valid[3]`: `press_count[3]`=0 on the next cycle.
- With `BUTTON_LONG_PRESS_EN`, channel 0 held 30 cycles: exactly one `long_press[0]` pulse, 16 cycles after `valid[0]`. Without the macro, `long_press` stays 0.

Source files
------------

// File: rtl/button_valid_pkg.sv
// Shared types and default parameters for the button_valid_array slice.
// Debounce FSM state encoding is shared by the per-channel module and any test code.
package button_valid_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } deb_state_t;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 8;
    localparam int DEF_LONG_CYCLES     = 16;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, press pulse and
// optional long-press detector (enabled by BUTTON_LONG_PRESS_EN).
module button_debounce_ch
    import button_valid_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    output logic o_pressed,
    output logic o_valid,
    output logic o_long_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic          r_sync_p0;
    logic          r_sync_p1;
    deb_state_t    r_state;
    deb_state_t    w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    logic          w_cnt_done;
    logic          w_accept_press;
    logic          w_accept_release;
    logic          r_pressed;
    logic          r_valid;

    // Count is 0 in the stable states, so "done" there means DEBOUNCE_CYCLES == 1.
    assign w_cnt_done = (32'(r_cnt) + 32'd1) >= 32'(DEBOUNCE_CYCLES);

    // ---- stage p0/p1: synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= i_button;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // ---- debounce FSM on the synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            LOW: begin
                if (r_sync_p1) begin
                    if (w_cnt_done) begin
                        w_next_state   = HIGH;
                        w_next_cnt     = '0;
                        w_accept_press = 1'b1;
                    end else begin
                        w_next_state = CHK_HI;
                        w_next_cnt   = CW'(1);
                    end
                end
            end
            CHK_HI: begin
                if (!r_sync_p1) begin
                    w_next_state = LOW;
                    w_next_cnt   = '0;
                end else if (w_cnt_done) begin
                    w_next_state   = HIGH;
                    w_next_cnt     = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            HIGH: begin
                if (!r_sync_p1) begin
                    if (w_cnt_done) begin
                        w_next_state     = LOW;
                        w_next_cnt       = '0;
                        w_accept_release = 1'b1;
                    end else begin
                        w_next_state = CHK_LO;
                        w_next_cnt   = CW'(1);
                    end
                end
            end
            CHK_LO: begin
                if (r_sync_p1) begin
                    w_next_state = HIGH;
                    w_next_cnt   = '0;
                end else if (w_cnt_done) begin
                    w_next_state     = LOW;
                    w_next_cnt       = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_next_state = LOW;
                w_next_cnt   = '0;
            end
        endcase
    end

    // ---- registered outputs, aligned with the accepting state transition
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pressed <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_accept_press;
            if (w_accept_press) begin
                r_pressed <= 1'b1;
            end else if (w_accept_release) begin
                r_pressed <= 1'b0;
            end
        end
    end

    assign o_pressed = r_pressed;
    assign o_valid   = r_valid;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;

    logic [HW-1:0] r_hold;
    logic          r_long;
    logic          w_held;

    // Only count cycles spent entirely inside the held region, so the
    // acceptance edge itself is cycle 0 and release acceptance clears it.
    assign w_held = ((r_state == HIGH) || (r_state == CHK_LO)) &&
                    ((w_next_state == HIGH) || (w_next_state == CHK_LO));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= w_held && (32'(r_hold) == 32'(LONG_CYCLES - 1));
            if (!w_held) begin
                r_hold <= '0;
            end else if (32'(r_hold) != 32'(LONG_CYCLES)) begin
                r_hold <= r_hold + HW'(1);
            end
        end
    end

    assign o_long_press = r_long;
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/button_valid_array.sv
// Multi-channel debounced button front end with per-channel wrapping press counters.
// Long-press detection is compiled in only when BUTTON_LONG_PRESS_EN is defined.
module button_valid_array
    import button_valid_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       button,
    input  logic                      clear,
    output logic [CHANNELS-1:0]       pressed,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS*CNT_W-1:0] press_count,
    output logic [CHANNELS-1:0]       long_press
);

    logic [CHANNELS-1:0] w_valid;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] r_press_cnt;

        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_button     (button[g]),
            .o_pressed    (pressed[g]),
            .o_valid      (w_valid[g]),
            .o_long_press (long_press[g])
        );

        // ---- counter stage: one cycle behind valid; clear overrides a coincident press
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                r_press_cnt <= '0;
            end else if (w_valid[g]) begin
                r_press_cnt <= r_press_cnt + CNT_W'(1);
            end
        end

        assign press_count[g*CNT_W +: CNT_W] = r_press_cnt;
    end

    assign valid = w_valid;

endmodule
